accum_out_drain: RTL and testbench

Reader at the far end of the accumulator output FIFO: the 64-bit registered-output FIFO holding {acc_0, acc_1} fp results.
- On a job start, pops a programmed number of entries from that FIFO.
- Buffers them through a 2-entry skid stage.
- Presents them as addressed write beats (valid/ready) to the output/unified buffer, then pulses done.

---
 rtl/accum_out_drain.sv | 228 ++++++++++++++++++++++
 tb/tb_accum_out_drain.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_out_drain.sv
// accum_out_drain: drains a programmed number of {acc_0, acc_1} entries from the
// accumulator output FIFO through a 2-entry skid into addressed write beats.
// Define ACCUM_OUT_STATUS_EN to add the o_stall_cycles sink-stall counter.
module accum_out_drain #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [CNT_WIDTH-1:0]    i_count,
  output logic                    o_busy,
  output logic                    o_done,
  input  logic                    i_fifo_empty,
  output logic                    o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   i_fifo_data_0,
  input  logic [DATA_WIDTH-1:0]   i_fifo_data_1,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic [ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [2*DATA_WIDTH-1:0] o_wr_data
`ifdef ACCUM_OUT_STATUS_EN
  ,
  output logic [15:0]             o_stall_cycles
`endif
);

  localparam int BEAT_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  // Job bookkeeping
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_reads;
  logic [CNT_WIDTH-1:0]  r_beats;
  logic [CNT_WIDTH-1:0]  w_beats_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;

  // Read pipeline and skid storage
  logic                  r_inflight;
  logic [BEAT_W-1:0]     r_skid_0;
  logic [BEAT_W-1:0]     r_skid_1;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;

  // Registered status outputs
  logic                  r_busy;
  logic                  r_done;

  logic                  w_start_acc;
  logic                  w_rd_en;
  logic [1:0]            w_pending;
  logic                  w_head_vld;
  logic [BEAT_W-1:0]     w_head_dat;
  logic [BEAT_W-1:0]     w_fifo_dat;
  logic                  w_xfer;
  logic                  w_cap;
  logic                  w_pop;

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_fifo_dat  = {i_fifo_data_0, i_fifo_data_1};
  assign w_beats_nxt = r_beats + CNT_WIDTH'(w_xfer);
  assign w_xfer      = w_head_vld && i_wr_ready;

  // The entry arriving from the FIFO is stored in the skid unless the skid is
  // empty and the sink takes it straight away in its arrival cycle.
  assign w_cap       = r_inflight && !((r_occ == 2'd0) && w_xfer);
  assign w_pop       = w_xfer && (r_occ != 2'd0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: leave RUN in the cycle the last beat is handed over
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (i_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((r_reads == r_count) && (w_beats_nxt == r_count)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM outputs: pop gating and beat head selection. An entry in flight counts
  // against the two skid slots, so the skid can never overflow. When the skid
  // is empty the arriving FIFO word is presented directly, which gives the
  // two-cycle start-to-first-beat latency; if it stalls it is captured into the
  // skid and re-presented unchanged from there.
  always_comb begin
    w_pending  = r_occ + {1'b0, r_inflight};
    w_rd_en    = (r_state == S_RUN) && !i_fifo_empty &&
                 (r_reads < r_count) && (w_pending < 2'd2);
    w_head_vld = (r_occ != 2'd0) || r_inflight;
    w_head_dat = w_fifo_dat;
    if (r_occ != 2'd0) begin
      w_head_dat = r_rd_ptr ? r_skid_1 : r_skid_0;
    end
  end

  // Job parameters, read/beat counters and the running write address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_reads <= '0;
      r_beats <= '0;
      r_addr  <= '0;
    end else if (w_start_acc) begin
      r_count <= i_count;
      r_reads <= '0;
      r_beats <= '0;
      r_addr  <= i_base_addr;
    end else begin
      if (w_rd_en) begin
        r_reads <= r_reads + CNT_WIDTH'(1);
      end
      if (w_xfer) begin
        r_beats <= w_beats_nxt;
        r_addr  <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Remember a pop so its data is captured when the FIFO presents it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  // Two-slot skid: write at the tail on capture, advance the head on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_0 <= '0;
      r_skid_1 <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_cap) begin
        if (r_wr_ptr) begin
          r_skid_1 <= w_fifo_dat;
        end else begin
          r_skid_0 <= w_fifo_dat;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_cap, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Busy from accepted start until the DONE state; done one cycle after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_start_acc) begin
        r_busy <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

`ifdef ACCUM_OUT_STATUS_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of cycles a beat waits on the sink during a job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_start_acc) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_RUN) && w_head_vld && !i_wr_ready &&
                 (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fifo_rd_en = w_rd_en;
  assign o_wr_valid   = w_head_vld;
  assign o_wr_addr    = r_addr;
  assign o_wr_data    = w_head_vld ? w_head_dat : '0;

endmodule

// File: tb/tb_accum_out_drain.sv
// Bench for accum_out_drain: FIFO model with registered read data, randomised
// sink ready, scoreboard of expected {addr, data} beats built from FIFO contents.
module tb_accum_out_drain;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic [AW-1:0]   i_base_addr = '0;
  logic [CW-1:0]   i_count = '0;
  logic            o_busy, o_done;
  logic            i_fifo_empty = 1'b1;
  logic            o_fifo_rd_en;
  logic [DW-1:0]   i_fifo_data_0 = '0;
  logic [DW-1:0]   i_fifo_data_1 = '0;
  logic            o_wr_valid;
  logic            i_wr_ready = 1'b1;
  logic [AW-1:0]   o_wr_addr;
  logic [2*DW-1:0] o_wr_data;
`ifdef ACCUM_OUT_STATUS_EN
  logic [15:0]     o_stall_cycles;
`endif

  always #5 clk = ~clk;

  accum_out_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_count(i_count), .o_busy(o_busy), .o_done(o_done),
    .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en),
    .i_fifo_data_0(i_fifo_data_0), .i_fifo_data_1(i_fifo_data_1),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data)
`ifdef ACCUM_OUT_STATUS_EN
    , .o_stall_cycles(o_stall_cycles)
`endif
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [63:0] d;
  } beat_t;

  typedef struct {
    int         preload;
    int         gap;
    logic [7:0] base;
    int         cnt;
    int         rmode;
    int         exp_pops;
    int         exp_left;
    int         exp_done_lat;
  } vec_t;

  int          vec_n = 0, err_n = 0;
  int          cyc = 0;
  logic [63:0] fq[$];
  logic [63:0] src[$];
  beat_t       exp_q[$];
  logic [63:0] pop_dat = '0;
  int          pops_total = 0, beats_total = 0, done_cnt = 0, busy_cnt = 0;
  int          stall_cnt = 0, done_cyc = 0, rise_cyc = 0;
  int          rmode = 0, gap = 0, gcnt = 0, pidx = 0;
  logic        prev_vld = 1'b0, prev_stall = 1'b0, mon_en = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [63:0] prev_dat = '0;
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int          c0, p0, d0, b0, s0, bt0;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: pop on a sampled rd_en, optional trickle of arriving entries
  task automatic fifo_loop();
    forever begin
      @(posedge clk);
      cyc++;
      if (o_fifo_rd_en) begin
        pops_total++;
        if (fq.size() > 0) pop_dat = fq.pop_front();
      end
      if (gap > 0 && src.size() > 0) begin
        gcnt++;
        if (gcnt >= gap) begin
          gcnt = 0;
          fq.push_back(src.pop_front());
        end
      end
    end
  endtask

  // Drives sink ready and FIFO outputs, then checks beats and invariants
  task automatic mon_loop();
    beat_t e;
    forever begin
      @(negedge clk);
      case (rmode)
        0:       i_wr_ready = 1'b1;
        1:       begin i_wr_ready = pat[pidx % 6]; pidx++; end
        default: i_wr_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      i_fifo_empty  = (fq.size() == 0);
      i_fifo_data_0 = pop_dat[63:32];
      i_fifo_data_1 = pop_dat[31:0];
      #1;
      if (rst_n && mon_en) begin
        if (o_fifo_rd_en) chk("rd_en_while_empty", i_fifo_empty, 0);
        if (prev_stall) begin
          chk("stall_valid_hold", o_wr_valid, 1);
          chk("stall_addr_hold", o_wr_addr, prev_addr);
          chk("stall_data_hold", o_wr_data, prev_dat);
        end
        if (o_wr_valid && i_wr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_queue", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", o_wr_addr, e.a);
            chk("beat_data", o_wr_data, e.d);
          end
          beats_total++;
        end
        chk("pop_ahead_le2", (pops_total - beats_total) <= 2, 1);
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_busy) busy_cnt++;
        if (o_wr_valid && !prev_vld) rise_cyc = cyc;
        if (o_wr_valid && !i_wr_ready) stall_cnt++;
      end
      prev_vld   = o_wr_valid;
      prev_stall = o_wr_valid && !i_wr_ready && rst_n;
      prev_addr  = o_wr_addr;
      prev_dat   = o_wr_data;
    end
  endtask

  task automatic preload(input int n, input int g, input int tag, input bit rnd);
    logic [31:0] l0;
    fq.delete();
    src.delete();
    gcnt = 0;
    gap  = g;
    for (int k = 1; k <= n; k++) begin
      l0 = rnd ? $urandom : 32'(k + tag * 16);
      if (g > 0) src.push_back({l0, rnd ? $urandom : l0 + 32'h100});
      else       fq.push_back({l0, rnd ? $urandom : l0 + 32'h100});
    end
  endtask

  task automatic start_job(input logic [7:0] base, input int cnt);
    logic [63:0] all[$];
    beat_t b;
    all.delete();
    foreach (fq[i])  all.push_back(fq[i]);
    foreach (src[i]) all.push_back(src[i]);
    for (int i = 0; i < cnt; i++) begin
      b.a = base + 8'(i);
      b.d = all[i];
      exp_q.push_back(b);
    end
    @(negedge clk);
    i_start = 1'b1; i_base_addr = base; i_count = CW'(cnt);
    c0 = cyc; p0 = pops_total; d0 = done_cnt; b0 = busy_cnt; s0 = stall_cnt; bt0 = beats_total;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic finish_job(input int exp_pops, input int exp_left, input int lat, input int cnt);
    int t = 0;
    while (done_cnt == d0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    #3;
    chk("done_pulses", done_cnt - d0, 1);
    chk("rd_en_pulses", pops_total - p0, exp_pops);
    chk("fifo_left", fq.size() + src.size(), exp_left);
    chk("beats_outstanding", exp_q.size(), 0);
    chk("busy_after_done", o_busy, 0);
    if (lat >= 0) begin
      chk("done_latency", done_cyc - c0, lat);
      chk("busy_cycles", busy_cnt - b0, (cnt == 0) ? 1 : cnt + 2);
      if (cnt > 0) chk("first_beat_latency", rise_cyc - c0, 2);
    end
`ifdef ACCUM_OUT_STATUS_EN
    chk("stall_cycles", o_stall_cycles, stall_cnt - s0);
`endif
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rd_en"}, o_fifo_rd_en, 0);
    chk({tag, "_wr_valid"}, o_wr_valid, 0);
    chk({tag, "_wr_addr"}, o_wr_addr, 0);
    chk({tag, "_wr_data"}, o_wr_data, 0);
`ifdef ACCUM_OUT_STATUS_EN
    chk({tag, "_stall"}, o_stall_cycles, 0);
`endif
  endtask

  initial begin
    int n, cnt;
    fork
      fifo_loop();
      mon_loop();
    join_none

    // Reset state
    #3;
    chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // preload, gap, base, cnt, ready mode, pops, left, done latency
    tbl[0] = '{4,  0, 8'h10, 4,  0, 4,  0, 7};
    tbl[1] = '{6,  0, 8'h20, 3,  0, 3,  3, 6};
    tbl[2] = '{2,  0, 8'h30, 0,  0, 0,  2, 2};
    tbl[3] = '{5,  0, 8'h40, 5,  1, 5,  0, -1};
    tbl[4] = '{4,  0, 8'hFE, 4,  0, 4,  0, 7};
    tbl[5] = '{6,  0, 8'hF0, 6,  2, 6,  0, -1};
    tbl[6] = '{5,  3, 8'h80, 5,  1, 5,  0, -1};
    tbl[7] = '{64, 0, 8'hC0, 64, 2, 64, 0, -1};
    for (int i = 0; i < 8; i++) begin
      rmode = tbl[i].rmode;
      preload(tbl[i].preload, tbl[i].gap, i, 1'b0);
      start_job(tbl[i].base, tbl[i].cnt);
      finish_job(tbl[i].exp_pops, tbl[i].exp_left, tbl[i].exp_done_lat, tbl[i].cnt);
    end

    // Randomised jobs
    for (int j = 0; j < 12; j++) begin
      n   = $urandom_range(0, 12);
      cnt = $urandom_range(0, n);
      rmode = 2;
      preload(n, $urandom_range(0, 2), 0, 1'b1);
      start_job(8'($urandom), cnt);
      finish_job(cnt, n - cnt, -1, cnt);
    end

    // Trickling FIFO with a second start while the job runs
    rmode = 1;
    preload(4, 3, 9, 1'b0);
    start_job(8'h60, 4);
    repeat (4) @(negedge clk);
    i_start = 1'b1; i_base_addr = 8'h00; i_count = CW'(2);
    #3;
    chk("busy_at_restart", o_busy, 1);
    @(negedge clk);
    i_start = 1'b0;
    finish_job(4, 0, -1, 4);

    // Reset during the second beat of a job
    rmode = 0;
    preload(4, 0, 10, 1'b0);
    start_job(8'h70, 4);
    n = 0;
    while ((beats_total - bt0) < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat1_before_reset", beats_total - bt0, 1);
    rst_n = 1'b0;
    #3;
    chk_outputs_zero("midjob_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pops_total;
    beats_total = pops_total;
    repeat (8) @(negedge clk);
    #3;
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_no_reads", pops_total - p0, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_wr_valid, 0);

    // Recovery job after the abort
    preload(4, 0, 11, 1'b0);
    start_job(8'h10, 4);
    finish_job(4, 0, 7, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
